// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and SDA mux codes for the I2C slave controller
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR_RX   = 4'd1,
        ADDR_CHK  = 4'd2,
        ACK_ADDR  = 4'd3,
        NACK_ADDR = 4'd4,
        LOAD      = 4'd5,
        SEND      = 4'd6,
        REL_SDA   = 4'd7,
        CHK_MACK  = 4'd8,
        MACK_OK   = 4'd9,
        POP       = 4'd10,
        MNACK     = 4'd11
    } state_t;

    localparam logic [1:0] SDA_IDLE = 2'd0;
    localparam logic [1:0] SDA_ACK  = 2'd1;
    localparam logic [1:0] SDA_NACK = 2'd2;
    localparam logic [1:0] SDA_TX   = 2'd3;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - sequencing FSM for the read-only I2C slave
module i2c_slave_ctrl
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       check_ack,
    input  logic       ack_done,
    input  logic       sda_in,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       tx_fifo_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       read_enable,
    output logic [1:0] sda_mode
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus conditions override any timer-driven step; STOP beats a coincident START.
    always_comb begin
        next_state = state;
        if (stop_found) begin
            next_state = IDLE;
        end else if (start_found) begin
            next_state = ADDR_RX;
        end else begin
            case (state)
                IDLE:      next_state = IDLE;
                ADDR_RX:   if (byte_received) next_state = ADDR_CHK;
                ADDR_CHK:  if (ack_prep)
                               next_state = (address_match && rw_mode) ? ACK_ADDR : NACK_ADDR;
                ACK_ADDR:  if (ack_done) next_state = LOAD;
                NACK_ADDR: if (ack_done) next_state = IDLE;
                LOAD:      next_state = SEND;
                SEND:      if (byte_received) next_state = REL_SDA;
                REL_SDA:   if (ack_prep) next_state = CHK_MACK;
                CHK_MACK:  if (check_ack) next_state = sda_in ? MNACK : MACK_OK;
                MACK_OK:   if (ack_done) next_state = POP;
                POP:       next_state = LOAD;
                MNACK:     if (ack_done) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_enable   = 1'b0;
        tx_enable   = 1'b0;
        load_data   = 1'b0;
        read_enable = 1'b0;
        sda_mode    = SDA_IDLE;
        case (state)
            ADDR_RX:   rx_enable = 1'b1;
            ACK_ADDR:  sda_mode = SDA_ACK;
            NACK_ADDR: sda_mode = SDA_NACK;
            LOAD:      load_data = 1'b1;
            SEND: begin
                tx_enable = 1'b1;
                sda_mode  = SDA_TX;
            end
            // An empty FIFO still gets a load (don't-care data) but never a pop.
            POP:       read_enable = !tx_fifo_empty;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - directed self-checking bench for i2c_slave_ctrl
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_found, stop_found, byte_received, ack_prep, check_ack, ack_done;
    logic       sda_in, address_match, rw_mode, tx_fifo_empty;
    logic       rx_enable, tx_enable, load_data, read_enable;
    logic [1:0] sda_mode;

    int n_cmp = 0;
    int n_err = 0;

    // {start, stop, byte_received, ack_prep, check_ack, ack_done}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_START = 6'b100000;
    localparam logic [5:0] E_STOP  = 6'b010000;
    localparam logic [5:0] E_BYTE  = 6'b001000;
    localparam logic [5:0] E_PREP  = 6'b000100;
    localparam logic [5:0] E_CHK   = 6'b000010;
    localparam logic [5:0] E_DONE  = 6'b000001;
    localparam logic [5:0] E_BOTH  = 6'b110000;

    // {rx_enable, tx_enable, load_data, read_enable, sda_mode}
    localparam logic [5:0] O_ZERO = 6'b000000;
    localparam logic [5:0] O_RX   = 6'b100000;
    localparam logic [5:0] O_ACK  = 6'b000001;
    localparam logic [5:0] O_NACK = 6'b000010;
    localparam logic [5:0] O_LOAD = 6'b001000;
    localparam logic [5:0] O_SEND = 6'b010011;
    localparam logic [5:0] O_POP  = 6'b000100;

    i2c_slave_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .check_ack     (check_ack),
        .ack_done      (ack_done),
        .sda_in        (sda_in),
        .address_match (address_match),
        .rw_mode       (rw_mode),
        .tx_fifo_empty (tx_fifo_empty),
        .rx_enable     (rx_enable),
        .tx_enable     (tx_enable),
        .load_data     (load_data),
        .read_enable   (read_enable),
        .sda_mode      (sda_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [5:0] e);
        {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = e;
        tick();
        {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = E_NONE;
    endtask

    task automatic chk(input string tag, input logic [5:0] expv);
        logic [5:0] obs;
        obs = {rx_enable, tx_enable, load_data, read_enable, sda_mode};
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Drives a matched read address and stops once the first byte is in SEND.
    task automatic to_send();
        ev(E_START);
        ev(E_BYTE);
        ev(E_PREP);
        ev(E_DONE);
        tick();
    endtask

    initial begin
        n_rst = 1'b0;
        {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = E_NONE;
        sda_in = 1'b1; address_match = 1'b1; rw_mode = 1'b1; tx_fifo_empty = 1'b0;
        tick(); tick();
        chk("reset_outputs", O_ZERO);
        n_rst = 1'b1;
        tick();

        // matched read, first byte acked by master, second NACKed
        ev(E_START);  chk("start_rx", O_RX);
        ev(E_BYTE);   chk("addr_chk", O_ZERO);
        ev(E_PREP);   chk("ack_addr", O_ACK);
        tick();       chk("ack_addr_hold", O_ACK);
        ev(E_CHK);    chk("ack_addr_ignore_chk", O_ACK);
        ev(E_DONE);   chk("load_1", O_LOAD);
        tick();       chk("send_1", O_SEND);
        tick();       chk("send_1_hold", O_SEND);
        ev(E_BYTE);   chk("rel_sda_1", O_ZERO);
        ev(E_PREP);   chk("chk_mack_1", O_ZERO);
        sda_in = 1'b0;
        ev(E_CHK);    chk("mack_ok", O_ZERO);
        sda_in = 1'b1;
        ev(E_DONE);   chk("pop", O_POP);
        tick();       chk("load_2", O_LOAD);
        tick();       chk("send_2", O_SEND);
        ev(E_BYTE);   chk("rel_sda_2", O_ZERO);
        ev(E_PREP);   chk("chk_mack_2", O_ZERO);
        ev(E_CHK);    chk("mnack", O_ZERO);
        ev(E_DONE);   chk("mnack_idle", O_ZERO);
        ev(E_BYTE);   chk("idle_ignores_byte", O_ZERO);
        ev(E_DONE);   chk("idle_ignores_done", O_ZERO);

        // address mismatch
        address_match = 1'b0;
        ev(E_START);  chk("mis_start", O_RX);
        ev(E_BYTE);   chk("mis_chk", O_ZERO);
        ev(E_PREP);   chk("mis_nack", O_NACK);
        ev(E_DONE);   chk("mis_idle", O_ZERO);
        tick();       chk("mis_no_load", O_ZERO);

        // matching address but master write
        address_match = 1'b1; rw_mode = 1'b0;
        ev(E_START); ev(E_BYTE);
        ev(E_PREP);   chk("write_nack", O_NACK);
        ev(E_DONE);   chk("write_idle", O_ZERO);
        rw_mode = 1'b1;

        // empty FIFO at POP
        tx_fifo_empty = 1'b1;
        to_send();    chk("empty_send", O_SEND);
        ev(E_BYTE); ev(E_PREP);
        sda_in = 1'b0;
        ev(E_CHK);
        sda_in = 1'b1;
        ev(E_DONE);   chk("empty_pop_no_read", O_ZERO);
        tick();       chk("empty_load", O_LOAD);
        tick();       chk("empty_send_2", O_SEND);
        tx_fifo_empty = 1'b0;

        // STOP during SEND
        ev(E_STOP);   chk("stop_in_send", O_ZERO);
        tick();       chk("stop_stays_idle", O_ZERO);

        // repeated START during REL_SDA
        to_send();
        ev(E_BYTE);   chk("rel_sda_rs", O_ZERO);
        ev(E_START);  chk("rs_addr_rx", O_RX);

        // simultaneous STOP and START: STOP wins, from ADDR_RX and from IDLE
        ev(E_BOTH);   chk("both_from_rx", O_ZERO);
        ev(E_BOTH);   chk("both_from_idle", O_ZERO);

        // async reset mid-SEND
        to_send();    chk("pre_reset_send", O_SEND);
        n_rst = 1'b0;
        #1;           chk("async_reset", O_ZERO);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("quiet_idle", O_ZERO);
        end
        ev(E_BYTE);   chk("post_reset_idle", O_ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
